timer_dev: RTL and testbench

- Memory-mapped programmable countdown timer on the processor device bus, downstream of the datapath's device port.
- The system bridge decodes the datapath's pr_addr, routes pr_data_out and the write strobe here, and returns dev_rdata on pr_data_in.
- irq drives one bit of the CP0 hw_int vector.
- Provides one-shot and auto-reload interrupt generation.

---
 rtl/timer_dev_pkg.sv | 32 +++
 rtl/timer_dev_if.sv | 10 +
 rtl/timer_dev_prescaler.sv | 30 +++
 rtl/timer_dev.sv | 145 ++++++++++++++
 tb/tb_timer_dev.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/timer_dev_pkg.sv
// Shared definitions for the timer device: register offsets, CTRL field
// positions, MODE encodings and the FSM state encoding. The bus bridge
// imports the same offsets.
package timer_dev_pkg;

    localparam logic [1:0] OFF_CTRL     = 2'd0;
    localparam logic [1:0] OFF_PRESET   = 2'd1;
    localparam logic [1:0] OFF_COUNT    = 2'd2;
    localparam logic [1:0] OFF_PRESCALE = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    // Field order matches the CTRL bit layout, so a cast from wdata[3:0] works.
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/timer_dev_if.sv
// Device-bus port between the system bridge (master) and the timer (slave).
interface timer_dev_if;
    logic [1:0]  dev_addr;
    logic        dev_we;
    logic [31:0] dev_wdata;
    logic [31:0] dev_rdata;

    modport master (output dev_addr, output dev_we, output dev_wdata, input dev_rdata);
    modport slave  (input dev_addr, input dev_we, input dev_wdata, output dev_rdata);
endinterface

// File: rtl/timer_dev_prescaler.sv
// Count tick generator for the timer. Only built when TIMER_PRESCALE_EN is
// defined; tick_o fires once every (prescale_i+1) cycles after clear_i drops.
`ifdef TIMER_PRESCALE_EN
module timer_dev_prescaler #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic [W-1:0] prescale_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // >= rather than == so a PRESCALE write lowering the limit cannot strand the counter.
    always_comb begin
        tick_o = (cnt_q >= prescale_i);
        cnt_d  = cnt_q + 1'b1;
        if (clear_i || tick_o) cnt_d = '0;
    end

    // Prescale counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule
`endif

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with one-shot and auto-reload interrupts.
// Optional prescaler on offset 3 is enabled by defining TIMER_PRESCALE_EN.
//
// state | meaning
// IDLE  | timer stopped, waiting for EN
// LOAD  | COUNT <= PRESET
// CNT   | counting down; COUNT==0 moves to INT
// INT   | terminal count; one-shot holds until CTRL/PRESET write, reload lasts one cycle
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int PRESCALE_W = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    timer_dev_if.slave bus,
    output logic       irq_o
);

    if (CNT_W < 1 || CNT_W > 32 || PRESCALE_W < 1 || PRESCALE_W > 32) begin : g_bad_param
        $error("timer_dev: CNT_W and PRESCALE_W must be within 1..32");
    end

    state_e           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             irq_q, irq_d;

    logic ctrl_we, preset_we, en_sw, im_sw, reload_mode, cnt_zero, tick;
    logic load_cnt, dec_cnt, hw_clr_en;

    // A CTRL store acts on the FSM in the same edge it lands, so the bus value
    // is looked at ahead of the register.
    assign ctrl_we     = bus.dev_we && (bus.dev_addr == OFF_CTRL);
    assign preset_we   = bus.dev_we && (bus.dev_addr == OFF_PRESET);
    assign en_sw       = ctrl_we ? bus.dev_wdata[CTRL_EN_BIT] : ctrl_q.en;
    assign im_sw       = ctrl_we ? bus.dev_wdata[CTRL_IM_BIT] : ctrl_q.im;
    assign reload_mode = (ctrl_q.mode == MODE_RELOAD);
    assign cnt_zero    = (count_q == '0);

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  prescale_we;

    assign prescale_we = bus.dev_we && (bus.dev_addr == OFF_PRESCALE);

    // PRESCALE register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)          prescale_q <= '0;
        else if (prescale_we) prescale_q <= bus.dev_wdata[PRESCALE_W-1:0];
    end

    timer_dev_prescaler #(.W(PRESCALE_W)) u_prescaler (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    ((state_q == ST_IDLE) || (state_q == ST_LOAD)),
        .prescale_i (prescale_q),
        .tick_o     (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (en_sw) state_d = ST_LOAD;
            ST_LOAD: state_d = en_sw ? ST_CNT : ST_IDLE;
            ST_CNT: begin
                if (!en_sw)        state_d = ST_IDLE;
                else if (cnt_zero) state_d = ST_INT;
            end
            ST_INT: begin
                // One-shot has already dropped EN, so only a register store releases it.
                if (reload_mode)                 state_d = en_sw ? ST_LOAD : ST_IDLE;
                else if (ctrl_we || preset_we)   state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: datapath strobes and the next irq value.
    always_comb begin
        load_cnt  = (state_q == ST_LOAD) && (state_d == ST_CNT);
        dec_cnt   = (state_q == ST_CNT) && (state_d == ST_CNT) && tick && !cnt_zero;
        hw_clr_en = (state_q == ST_CNT) && (state_d == ST_INT) && !reload_mode;
        irq_d     = (state_d == ST_INT) && im_sw;
    end

    // Register next values; a software CTRL store overrides the hardware EN clear.
    always_comb begin
        ctrl_d = ctrl_q;
        if (hw_clr_en) ctrl_d.en = 1'b0;
        if (ctrl_we)   ctrl_d = ctrl_t'(bus.dev_wdata[CTRL_IM_BIT:CTRL_EN_BIT]);

        preset_d = preset_we ? bus.dev_wdata[CNT_W-1:0] : preset_q;

        count_d = count_q;
        if (load_cnt)     count_d = preset_q;
        else if (dec_cnt) count_d = count_q - 1'b1;
    end

    // CTRL, PRESET, COUNT and irq registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_o = irq_q;

    // Side-effect-free read mux.
    always_comb begin
        bus.dev_rdata = '0;
        unique case (bus.dev_addr)
            OFF_CTRL:     bus.dev_rdata = 32'(ctrl_q);
            OFF_PRESET:   bus.dev_rdata = 32'(preset_q);
            OFF_COUNT:    bus.dev_rdata = 32'(count_q);
`ifdef TIMER_PRESCALE_EN
            OFF_PRESCALE: bus.dev_rdata = 32'(prescale_q);
`else
            OFF_PRESCALE: bus.dev_rdata = '0;
`endif
            default:      bus.dev_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev. Writes land on the posedge after the negedge
// they are set up on; all observations are taken 1 ns (plus read settle) after
// a posedge. Define TIMER_PRESCALE_EN to exercise the prescaler build.
`timescale 1ns/1ps
module tb_timer_dev;
    import timer_dev_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic irq;
    int   errors = 0;
    int   checks = 0;

    timer_dev_if bus();

    timer_dev dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus),
        .irq_o  (irq)
    );

    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.dev_addr  = a;
        bus.dev_wdata = d;
        bus.dev_we    = 1'b1;
        @(posedge clk);
        #1;
        bus.dev_we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.dev_addr = a;
        #1;
        d = bus.dev_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rd(OFF_CTRL, d);   checks++; if (d !== 32'h0) begin errors++; $display("FAIL por_ctrl got=%h exp=0", d); end
        rd(OFF_COUNT, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL por_count got=%h exp=0", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL por_irq got=%b exp=0", irq); end
        write_reg(OFF_PRESET, 32'd8);
        write_reg(OFF_CTRL, 32'h9);
        step(4);
        rd(OFF_COUNT, d);  checks++; if (d !== 32'd5) begin errors++; $display("FAIL midcount_count got=%0d exp=5", d); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", irq); end
        rd(OFF_CTRL, d);     checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl got=%h exp=0", d); end
        rd(OFF_PRESET, d);   checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_preset got=%h exp=0", d); end
        rd(OFF_COUNT, d);    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_count got=%h exp=0", d); end
        rd(OFF_PRESCALE, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_prescale got=%h exp=0", d); end
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        rd(OFF_COUNT, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_rst_count got=%h exp=0", d); end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        logic [31:0] exp;
        write_reg(OFF_PRESET, 32'd3);
        write_reg(OFF_CTRL, 32'h9);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            exp = 32'(4 - k);
            rd(OFF_COUNT, d);
            checks++; if (d !== exp) begin errors++; $display("FAIL oneshot_count E+%0d got=%0d exp=%0d", k, d, exp); end
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_early_irq E+%0d got=%b exp=0", k, irq); end
        end
        for (int k = 5; k <= 7; k++) begin
            step(1);
            checks++; if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq E+%0d got=%b exp=1", k, irq); end
        end
        rd(OFF_CTRL, d);
        checks++; if (d !== 32'h8) begin errors++; $display("FAIL oneshot_ctrl_en_cleared got=%h exp=8", d); end
        write_reg(OFF_PRESET, 32'd5);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_drop got=%b exp=0", irq); end
        step(2);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_idle_irq got=%b exp=0", irq); end
    endtask

    task automatic test_autoreload();
        logic [31:0] d;
        logic [15:0] trace;
        logic [31:0] exp;
        trace = '0;
        write_reg(OFF_PRESET, 32'd2);
        write_reg(OFF_CTRL, 32'hB);
        trace[0] = irq;
        for (int k = 1; k < 16; k++) begin
            step(1);
            trace[k] = irq;
            if (k == 5 || k == 6) begin
                exp = (k == 5) ? 32'd0 : 32'd2;
                rd(OFF_COUNT, d);
                checks++; if (d !== exp) begin errors++; $display("FAIL reload_count E+%0d got=%0d exp=%0d", k, d, exp); end
            end
        end
        checks++; if (trace !== 16'h4210) begin errors++; $display("FAIL reload_irq_trace got=%h exp=4210", trace); end
        rd(OFF_CTRL, d);
        checks++; if (d !== 32'hB) begin errors++; $display("FAIL reload_ctrl_kept got=%h exp=b", d); end
        write_reg(OFF_CTRL, 32'h0);
        step(6);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reload_stopped_irq got=%b exp=0", irq); end
    endtask

    task automatic test_masked();
        logic [31:0] d;
        logic        seen;
        seen = 1'b0;
        write_reg(OFF_PRESET, 32'd1);
        write_reg(OFF_CTRL, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            seen = seen | irq;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL masked_irq got=%b exp=0", seen); end
        rd(OFF_COUNT, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL masked_count got=%0d exp=0", d); end
        rd(OFF_CTRL, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL masked_ctrl got=%h exp=0", d); end
    endtask

    task automatic test_preset_during_cnt();
        logic [31:0] d;
        write_reg(OFF_PRESET, 32'd6);
        write_reg(OFF_CTRL, 32'h9);
        step(3);
        rd(OFF_COUNT, d); checks++; if (d !== 32'd4) begin errors++; $display("FAIL pcnt_count4 got=%0d exp=4", d); end
        write_reg(OFF_PRESET, 32'd9);
        rd(OFF_COUNT, d); checks++; if (d !== 32'd3) begin errors++; $display("FAIL pcnt_unaffected got=%0d exp=3", d); end
        write_reg(OFF_CTRL, 32'h0);
        rd(OFF_COUNT, d); checks++; if (d !== 32'd3) begin errors++; $display("FAIL pcnt_stop_hold got=%0d exp=3", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL pcnt_stop_irq got=%b exp=0", irq); end
        step(3);
        rd(OFF_COUNT, d); checks++; if (d !== 32'd3) begin errors++; $display("FAIL pcnt_idle_hold got=%0d exp=3", d); end
        write_reg(OFF_COUNT, 32'h55);
        rd(OFF_COUNT, d); checks++; if (d !== 32'd3) begin errors++; $display("FAIL count_readonly got=%0d exp=3", d); end
        write_reg(OFF_CTRL, 32'h9);
        step(1);
        rd(OFF_COUNT, d); checks++; if (d !== 32'd9) begin errors++; $display("FAIL pcnt_new_preset got=%0d exp=9", d); end
        write_reg(OFF_CTRL, 32'h0);
    endtask

    task automatic test_simultaneous_clear();
        logic [31:0] d;
        write_reg(OFF_PRESET, 32'd1);
        write_reg(OFF_CTRL, 32'h9);
        step(2);
        write_reg(OFF_CTRL, 32'hB);
        rd(OFF_CTRL, d); checks++; if (d !== 32'hB) begin errors++; $display("FAIL sim_sw_wins got=%h exp=b", d); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL sim_irq got=%b exp=1", irq); end
        step(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL sim_irq_pulse got=%b exp=0", irq); end
        step(1);
        rd(OFF_COUNT, d); checks++; if (d !== 32'd1) begin errors++; $display("FAIL sim_reload got=%0d exp=1", d); end
        write_reg(OFF_CTRL, 32'h0);
    endtask

    task automatic test_prescale();
        logic [31:0] d;
`ifdef TIMER_PRESCALE_EN
        logic exp_irq;
        write_reg(OFF_PRESCALE, 32'd1);
        rd(OFF_PRESCALE, d); checks++; if (d !== 32'd1) begin errors++; $display("FAIL prescale_readback got=%0d exp=1", d); end
        write_reg(OFF_PRESET, 32'd2);
        write_reg(OFF_CTRL, 32'h9);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            exp_irq = (k >= 6);
            checks++; if (irq !== exp_irq) begin errors++; $display("FAIL prescale_irq E+%0d got=%b exp=%b", k, irq, exp_irq); end
        end
        write_reg(OFF_PRESET, 32'd0);
`else
        write_reg(OFF_PRESCALE, 32'hFFFF);
        rd(OFF_PRESCALE, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL prescale_absent got=%h exp=0", d); end
`endif
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.dev_addr  = 2'd0;
        bus.dev_we    = 1'b0;
        bus.dev_wdata = 32'h0;
        #25 rst_n = 1'b1;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_masked();
        test_preset_during_cnt();
        test_simultaneous_clear();
        test_prescale();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
